capture_sequencer: RTL



---
 rtl/capture_pkg.sv | 19 +
 rtl/capture_watchdog.sv | 45 ++++
 rtl/capture_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the lidar capture sequencer: the sequencer state
//   type (its 3-bit encoding is also what the status register reports) and
//   the default widths of the pulse count and the watchdog limit.
package capture_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned TMO_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_TMO     = 3'd5
    } cap_state_t;

endpackage

// File: rtl/capture_watchdog.sv
// capture_watchdog
//   Saturating stall counter with a loadable limit.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     i_load      latch i_limit (accepted run start)
//     i_limit     cycle limit; 0 disables expiry
//     i_clear     zero the counter (has priority over i_enable)
//     i_enable    count one cycle, saturating at all-ones
//     o_expired   limit nonzero and counter has reached it
module capture_watchdog
    import capture_pkg::*;
#(
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMO_W-1:0] i_limit,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_limit;
    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_limit <= '0;
            r_count <= '0;
        end else begin
            if (i_load) begin
                r_limit <= i_limit;
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (i_enable && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_expired = (r_limit != '0) && (r_count >= r_limit);

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Runs one accumulation run of the lidar capture path: arms on start, waits
//   for a quiet data-valid, enables the pulse counter until the target shot
//   count is reached, drains for DRAIN_CYCLES, then reports done (or timeout
//   if the pulse count stalls for the watchdog limit).
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     start_i, abort_i   single-cycle run request / abort request
//     target_pulses_i    shots per run, latched on accepted start
//     timeout_cycles_i   stall limit, latched on accepted start (0 = off)
//     data_valid_i       per-shot data valid from the segment datapath
//     pulse_counts_i     count returned by the pulse counter
//     capture_en_o       enable to pulse counter / accumulator
//     busy_o             high whenever not IDLE
//     done_o, timeout_o  one-cycle completion / watchdog pulses
//     result_counts_o    pulse count captured at run end
//     state_o            current state encoding
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned TMO_W        = TMO_W_DEF,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] target_pulses_i,
    input  logic [TMO_W-1:0] timeout_cycles_i,
    input  logic             data_valid_i,
    input  logic [CNT_W-1:0] pulse_counts_i,
    output logic             capture_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] result_counts_o,
    output logic [2:0]       state_o
);

    localparam int unsigned      DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    cap_state_t       r_state;
    cap_state_t       w_next;
    logic             w_accept;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_prev_counts;
    logic [CNT_W-1:0] r_result;
    logic [DRN_W-1:0] r_drain_cnt;
    logic             r_cap_en;
    logic             r_busy;
    logic             r_done;
    logic             r_tmo;
    logic             w_wd_active;
    logic             w_wd_clear;
    logic             w_expired;
    logic             w_target_hit;

    // Watchdog only runs while waiting for shots; any count movement restarts it.
    assign w_wd_active  = (r_state == ST_ARM) || (r_state == ST_CAPTURE);
    assign w_wd_clear   = !w_wd_active || (pulse_counts_i != r_prev_counts);
    assign w_target_hit = (pulse_counts_i >= r_target);

    capture_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_limit   (timeout_cycles_i),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_active),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    w_next   = (target_pulses_i == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort_i)           w_next = ST_IDLE;
                else if (!data_valid_i) w_next = ST_CAPTURE;
                else if (w_expired)    w_next = ST_TMO;
            end
            ST_CAPTURE: begin
                if (abort_i)           w_next = ST_IDLE;
                else if (w_target_hit) w_next = ST_DRAIN;
                else if (w_expired)    w_next = ST_TMO;
            end
            ST_DRAIN: begin
                if (abort_i)                      w_next = ST_IDLE;
                else if (r_drain_cnt == DRN_LAST) w_next = ST_DONE;
            end
            ST_DONE, ST_TMO: w_next = ST_IDLE;
            default:         w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            r_prev_counts <= '0;
            r_result      <= '0;
            r_drain_cnt   <= '0;
            r_cap_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tmo         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_prev_counts <= pulse_counts_i;
            if (w_accept) begin
                r_target <= target_pulses_i;
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
            // Counter clears once enable drops, so sample it during DONE/TMO.
            if (((r_state == ST_DONE) || (r_state == ST_TMO)) && !abort_i) begin
                r_result <= pulse_counts_i;
            end
            // Flags are decoded from the next state so they line up with r_state.
            r_cap_en <= (w_next == ST_CAPTURE) || (w_next == ST_DRAIN);
            r_busy   <= (w_next != ST_IDLE);
            r_done   <= (w_next == ST_DONE);
            r_tmo    <= (w_next == ST_TMO);
        end
    end

    assign capture_en_o    = r_cap_en;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign timeout_o       = r_tmo;
    assign result_counts_o = r_result;
    assign state_o         = r_state;

endmodule
